// File: rtl/dsp_mac_acc.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mac_acc
//  Description : Pipelined signed multiply-accumulate block with an optional
//                pre-adder, add/subtract accumulation, saturating or wrapping
//                result, and valid/ready handshaking on both sides.
//
//  Pipeline    : S1 input register -> S2 product register (M) ->
//                S3 accumulator / result register (P).
//
//  Ports       : CLK, RST_N          clock, synchronous active-low reset
//                IN_VALID/IN_READY   input handshake
//                A, B, D             signed operands (D is the pre-adder input)
//                PREADD, SUB         product uses D+B; product is subtracted
//                CLR                 abort the accumulation in progress
//                M, M_VALID          registered product tap
//                P, OVF, OUT_VALID   result, overflow flag, result valid
//                OUT_READY           downstream accepts result
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_acc #(
    parameter int WIDTH_A = 18,
    parameter int WIDTH_B = 18,
    parameter int WIDTH_P = 48,
    parameter int ACC_LEN = 4,
    parameter int SAT_EN  = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    input  logic [WIDTH_B-1:0]         D,
    input  logic                       PREADD,
    input  logic                       SUB,
    input  logic                       CLR,
    output logic [WIDTH_A+WIDTH_B:0]   M,
    output logic                       M_VALID,
    output logic [WIDTH_P-1:0]         P,
    output logic                       OVF,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY
);

    localparam int c_M_W   = WIDTH_A + WIDTH_B + 1;
    localparam int c_CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [WIDTH_P-1:0] c_P_MAX = {1'b0, {(WIDTH_P-1){1'b1}}};
    localparam logic [WIDTH_P-1:0] c_P_MIN = {1'b1, {(WIDTH_P-1){1'b0}}};

    // Stage 1 registers
    logic                 r_s1_valid;
    logic [WIDTH_A-1:0]   r_s1_a;
    logic [WIDTH_B-1:0]   r_s1_b;
    logic [WIDTH_B-1:0]   r_s1_d;
    logic                 r_s1_pre;
    logic                 r_s1_sub;

    // Stage 2 registers
    logic [c_M_W-1:0]     r_m;
    logic                 r_m_valid;
    logic                 r_m_sub;

    // Stage 3 registers
    logic [WIDTH_P-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sticky;
    logic [WIDTH_P-1:0]   r_p;
    logic                 r_ovf;
    logic                 r_out_valid;

    logic                 w_en;
    logic signed [WIDTH_B:0]   w_preadd;
    logic signed [c_M_W-1:0]   w_prod;
    logic [WIDTH_P:0]     w_m_ext;
    logic [WIDTH_P:0]     w_acc_ext;
    logic [WIDTH_P:0]     w_sum;
    logic                 w_sum_ovf;
    logic [WIDTH_P-1:0]   w_sum_fit;
    logic                 w_last;

    // The whole pipeline freezes only while a finished result is waiting.
    assign w_en     = !(r_out_valid && !OUT_READY);
    assign IN_READY = w_en;

    // Pre-adder is one bit wider than B so D+B never overflows.
    assign w_preadd = r_s1_pre
                    ? ($signed({r_s1_d[WIDTH_B-1], r_s1_d}) + $signed({r_s1_b[WIDTH_B-1], r_s1_b}))
                    : $signed({r_s1_b[WIDTH_B-1], r_s1_b});

    assign w_prod = c_M_W'($signed(r_s1_a)) * c_M_W'(w_preadd);

    // Accumulate one bit wider than the result so overflow shows up as a
    // disagreement between the two top bits.
    assign w_m_ext   = {{(WIDTH_P+1-c_M_W){r_m[c_M_W-1]}}, r_m};
    assign w_acc_ext = {r_acc[WIDTH_P-1], r_acc};
    assign w_sum     = r_m_sub ? (w_acc_ext - w_m_ext) : (w_acc_ext + w_m_ext);
    assign w_sum_ovf = w_sum[WIDTH_P] ^ w_sum[WIDTH_P-1];
    assign w_last    = (r_cnt == c_CNT_W'(ACC_LEN - 1));

    always_comb begin
        w_sum_fit = w_sum[WIDTH_P-1:0];
        if ((SAT_EN != 0) && w_sum_ovf) begin
            w_sum_fit = w_sum[WIDTH_P] ? c_P_MIN : c_P_MAX;
        end
    end

    // Stages 1 and 2
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_d     <= '0;
            r_s1_pre   <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_m        <= '0;
            r_m_valid  <= 1'b0;
            r_m_sub    <= 1'b0;
        end else if (w_en) begin
            if (CLR) begin
                // A sample offered together with CLR is dropped.
                r_s1_valid <= 1'b0;
                r_m_valid  <= 1'b0;
            end else begin
                r_s1_valid <= IN_VALID;
                if (IN_VALID) begin
                    r_s1_a   <= A;
                    r_s1_b   <= B;
                    r_s1_d   <= D;
                    r_s1_pre <= PREADD;
                    r_s1_sub <= SUB;
                end
                r_m_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_m     <= w_prod;
                    r_m_sub <= r_s1_sub;
                end
            end
        end
    end

    // Stage 3: accumulator, counter and result register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            if (CLR) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sticky <= 1'b0;
                if (OUT_READY) begin
                    r_out_valid <= 1'b0;
                end
            end else if (r_m_valid && w_last) begin
                r_p         <= w_sum_fit;
                r_ovf       <= r_sticky | w_sum_ovf;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sticky    <= 1'b0;
            end else begin
                if (r_m_valid) begin
                    r_acc    <= w_sum_fit;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    r_sticky <= r_sticky | w_sum_ovf;
                end
                if (OUT_READY) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign M         = r_m;
    assign M_VALID   = r_m_valid;
    assign P         = r_p;
    assign OVF       = r_ovf;
    assign OUT_VALID = r_out_valid;

endmodule
`default_nettype wire
